// File: rtl/exc_sequencer.sv
// Exception/ERET sequencer between the M stage and CP0: synchronizes and gates
// device interrupts, strobes CP0, and flushes/redirects the pipeline.
`timescale 1ns/1ps

module exc_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          SYNC_STAGES  = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_valid,
    input  logic             m_exc,
    input  logic [4:0]       m_exc_code,
    input  logic [31:0]      m_pc,
    input  logic             m_bd,
    input  logic             m_eret,
    input  logic [5:0]       hw_int_async,
    input  logic             cp0_exc_now,
    input  logic [31:0]      cp0_epc,
    output logic             cp0_exc_req,
    output logic [4:0]       cp0_exc_code,
    output logic [29:0]      cp0_pc,
    output logic             cp0_bd,
    output logic [5:0]       cp0_hwint,
    output logic             cp0_exl_clr,
    output logic             m_kill,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] exc_count
);

    typedef enum logic [1:0] {IDLE, TRAP, RET} state_e;

    state_e                            state_q;
    logic [SYNC_STAGES-1:0][5:0]       sync_q;
    logic                              flush_q;
    logic                              redirect_valid_q;
    logic [31:0]                       redirect_pc_q;
    logic                              busy_q;
    logic [CNT_W-1:0]                  exc_count_q;

    logic [5:0] int_sync;
    logic       idle_valid;
    logic       take;
    logic       eret_go;
    logic       unused_pc_bits;

    // NOTE: every flop here, synchronizer included, gets an async reset so the
    // first post-reset cycle can never present stale interrupt levels to CP0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], hw_int_async};
        end
    end

    assign int_sync = sync_q[SYNC_STAGES-1];

    // Events are only visible while a real instruction sits in M and we are
    // not mid-redirect; reset also forces the strobes low.
    assign idle_valid = reset && (state_q == IDLE) && m_valid;
    assign take       = idle_valid && cp0_exc_now;
    assign eret_go    = idle_valid && m_eret && !cp0_exc_now;

    assign cp0_hwint    = idle_valid ? int_sync : 6'b0;
    assign cp0_exc_req  = idle_valid && m_exc;
    assign cp0_exl_clr  = eret_go;
    assign m_kill       = take || eret_go;
    assign cp0_exc_code = m_exc_code;
    assign cp0_pc       = m_pc[31:2];
    assign cp0_bd       = m_bd;

    assign unused_pc_bits = ^m_pc[1:0];

    // NOTE: state and registered outputs use non-blocking assignments so all
    // of them update together from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
            exc_count_q      <= '0;
        end else begin
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q          <= TRAP;
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= HANDLER_ADDR;
                        busy_q           <= 1'b1;
                        if (exc_count_q != '1) begin
                            exc_count_q <= exc_count_q + 1'b1;
                        end
                    end else if (eret_go) begin
                        state_q          <= RET;
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= cp0_epc;
                        busy_q           <= 1'b1;
                    end
                end
                TRAP:    state_q <= IDLE;
                RET:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign busy           = busy_q;
    assign exc_count      = exc_count_q;

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Sequences coprocessor-0 exception entry and ERET for the 5-stage MIPS pipeline.
- Sits between the M stage and CP0 and owns three things:
  - the hardware-interrupt synchronizer and its gating;
  - the CP0 request strobes;
  - the pipeline flush/redirect to the handler or to EPC.
- Interrupt gating guarantees CP0 only sees an event when the M stage holds a real instruction, so the PC written to EPC is always valid.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception handler entry PC.
- SYNC_STAGES, 2, flop depth of the hw_int synchronizer (≥2).
- CNT_W, 16, width of the saturating taken-exception counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- m_valid  in  1  M stage holds a real (non-bubble) instruction
- m_exc  in  1  M-stage instruction carries an exception
- m_exc_code  in  5  its ExcCode
- m_pc  in  32  M-stage PC
- m_bd  in  1  M-stage instruction is in a delay slot
- m_eret  in  1  M-stage instruction is ERET
- hw_int_async  in  6  raw device interrupt lines
- cp0_exc_now  in  1  CP0 "exception taken this cycle"
- cp0_epc  in  32  CP0 EPC value
- cp0_exc_req  out  1  exception request to CP0
- cp0_exc_code  out  5  ExcCode to CP0
- cp0_pc  out  30  PC[31:2] to CP0
- cp0_bd  out  1  BD to CP0
- cp0_hwint  out  6  gated, synchronized interrupts to CP0
- cp0_exl_clr  out  1  EXL clear to CP0
- m_kill  out  1  suppress M-stage commit (register file / memory write) this cycle
- flush  out  1  clear F/D/E/M pipeline registers
- redirect_valid  out  1  load PC from redirect_pc
- redirect_pc  out  32  new fetch PC
- busy  out  1  state ≠ IDLE
- exc_count  out  CNT_W  number of exceptions taken, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; synchronizer flops=0; epc_q=0; exc_count=0.
  - All outputs 0, except cp0_pc/cp0_exc_code/cp0_bd, which follow their inputs.
- Synchronizer:
  - hw_int_async passes through SYNC_STAGES flops to give int_sync.
  - Latency is SYNC_STAGES cycles.
- Interrupt gating:
  - cp0_hwint = int_sync when state==IDLE && m_valid; otherwise 6'b0.
- Pass-through: cp0_exc_code=m_exc_code, cp0_pc=m_pc[31:2], cp0_bd=m_bd.
- cp0_exc_req (combinational) = state==IDLE && m_valid && m_exc.
- take = state==IDLE && m_valid && cp0_exc_now.
  - m_kill = take || eret_go.
- eret_go = state==IDLE && m_valid && m_eret && !cp0_exc_now.
  - cp0_exl_clr = eret_go (combinational).
  - Exception/interrupt has priority over ERET in the same cycle.
- States:
  - IDLE:
    - take → TRAP, and exc_count += 1, saturating at all-ones.
    - eret_go → RET, and epc_q <= cp0_epc.
    - Else stay in IDLE.
  - TRAP (1 cycle):
    - flush=1, redirect_valid=1, redirect_pc=HANDLER_ADDR, busy=1.
    - m_valid, m_exc and m_eret are ignored; cp0_hwint=0.
    - → IDLE.
  - RET (1 cycle):
    - flush=1, redirect_valid=1, redirect_pc=epc_q, busy=1.
    - Inputs ignored; cp0_hwint=0.
    - → IDLE.
- Outputs in IDLE: flush=0, redirect_valid=0, redirect_pc=0.
- Back-to-back events:
  - An exception at M in the first IDLE cycle after TRAP or RET is accepted normally.
  - Minimum spacing between two redirects is 2 cycles.
- A bubble at M (m_valid=0) blocks all events, and interrupts stay pending at the synchronizer output.
  - Interrupts are level-sensitive; no pulse capture.
- cp0_exc_now asserted while m_valid=0 or state≠IDLE cannot occur by construction. The bench asserts this.
- Reset asserted mid-TRAP/RET forces IDLE immediately, with no redirect.

Test Plan:
- Reset release with all inputs 0:
  - busy=0, flush=0, exc_count=0, cp0_hwint=0.
- m_valid=1, m_exc=1, code=5'd4, m_pc=32'h0000_3010, m_bd=0, with CP0 model returning exc_now=1:
  - same cycle: cp0_exc_req=1, cp0_pc=30'h0C04, m_kill=1.
  - next cycle: flush=1, redirect_pc=32'h0000_4180.
  - following cycle: busy=0, exc_count=1.
- hw_int_async=6'b000100 while m_valid=0 for 5 cycles, then m_valid=1:
  - cp0_hwint=0 until m_valid=1.
  - cp0_hwint=6'b000100 no earlier than 2 cycles after the line rose.
- m_eret=1, m_valid=1, cp0_epc=32'h0000_3020, exc_now=0:
  - same cycle: cp0_exl_clr=1, m_kill=1.
  - next cycle: flush=1, redirect_pc=32'h0000_3020.
- m_eret=1 with m_exc=1 in the same cycle:
  - cp0_exl_clr=0, cp0_exc_req=1.
  - redirect_pc=32'h0000_4180.
- reset driven low in the TRAP cycle, exc_count preloaded to 16'hFFFF by repeated traps:
  - flush/redirect drop to 0 asynchronously.
  - After reset release, exc_count=0.
  - Separately, exc_count holds 16'hFFFF on a further trap (saturation).
